// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-stage types, encodings and state enum
package rv_pkg;
  typedef logic [31:0] word_t;
  localparam word_t NOP_INSTR = 32'h0000_0013;
  localparam word_t EBREAK_INSTR = 32'h0010_0073;
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULTED} fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, flush-to-bubble and hold
module ifid_reg
  import rv_pkg::*;
#(
  parameter word_t BUBBLE = NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  word_t pc_in,
  input  word_t instr_in,
  output word_t pc,
  output word_t instr,
  output logic  valid
);
  word_t pc_q, pc_d, instr_q, instr_d;
  logic valid_q, valid_d;
  always_comb begin
    pc_d = (load && !flush) ? pc_in : pc_q;
    instr_d = flush ? BUBBLE : load ? instr_in : instr_q;
    valid_d = flush ? 1'b0 : load ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign pc = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC/fetch FSM driving the async ROM and filling the IF/ID register
module if_stage
  import rv_pkg::*;
#(
  parameter int    TAM_POSICIONES = 1024,
  parameter word_t RESET_PC       = 32'h0000_0000,
  parameter word_t NOP_WORD       = NOP_INSTR,
  parameter word_t EBREAK_WORD    = EBREAK_INSTR,
  localparam int   ADDR_W         = $clog2(TAM_POSICIONES)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] INS_ADDRESS,
  input  word_t             INSTRUCTION_IN,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  word_t             TARGET,
  output word_t             IFID_PC,
  output word_t             IFID_INSTR,
  output logic              IFID_VALID,
  output logic              HALTED,
  output logic              FAULT,
  output word_t             FETCH_COUNT
);
  fetch_state_t state_q, state_d;
  word_t pc_q, pc_d, count_q, count_d, pc_plus4;
  logic fault_q, fault_d, halted_q, halted_d, load, flush, tgt_bad, end_bad, is_ebreak;
  assign pc_plus4 = pc_q + 32'd4;
  assign tgt_bad = (|TARGET[1:0]) || ((TARGET >> (ADDR_W + 2)) != 32'd0);
  assign end_bad = (pc_plus4 >> 2) >= 32'(TAM_POSICIONES);
  assign is_ebreak = INSTRUCTION_IN == EBREAK_WORD;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    load = 1'b0;
    flush = 1'b0;
    if (REDIRECT && state_q != FAULTED) begin
      flush = 1'b1;
      state_d = tgt_bad ? FAULTED : RUN;
      pc_d = tgt_bad ? pc_q : TARGET;
    end else if (state_q == BOOT) begin
      flush = 1'b1;
      state_d = RUN;
    end else if (!STALL) begin
      // the last in-range instruction is still latched valid before faulting
      load = state_q == RUN;
      flush = state_q != RUN;
      if (state_q == RUN) begin
        state_d = is_ebreak ? HALT : end_bad ? FAULTED : RUN;
        pc_d = (is_ebreak || end_bad) ? pc_q : pc_plus4;
      end
    end
    fault_d = fault_q || state_d == FAULTED;
    halted_d = state_d == HALT;
    count_d = count_q + 32'(load);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      count_q <= '0;
      fault_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
      halted_q <= halted_d;
    end
  end
  ifid_reg #(.BUBBLE(NOP_WORD)) u_ifid (
    .clk(CLK), .rst(RESET), .load(load), .flush(flush),
    .pc_in(pc_q), .instr_in(INSTRUCTION_IN),
    .pc(IFID_PC), .instr(IFID_INSTR), .valid(IFID_VALID)
  );
  assign INS_ADDRESS = pc_q[ADDR_W+1:2];
  assign HALTED = halted_q;
  assign FAULT = fault_q;
  assign FETCH_COUNT = count_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a scoreboard of expected IF/ID latches
module tb_if_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBR = 32'h0010_0073;

  logic clk = 0, rst = 1, stall = 0, redirect = 0, rst2 = 1;
  logic [31:0] target = 0;
  logic [9:0] addr;
  logic [1:0] addr2;
  logic [31:0] rom [0:1023];
  logic [31:0] ifid_pc, ifid_instr, fcount, ifid_pc2, ifid_instr2, fcount2;
  logic valid, halted, fault, valid2, halted2, fault2;
  int checks = 0, failures = 0;
  exp_t sb[$];
  logic [31:0] prev_cnt = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .CLK(clk), .RESET(rst), .INS_ADDRESS(addr), .INSTRUCTION_IN(rom[addr]),
    .STALL(stall), .REDIRECT(redirect), .TARGET(target),
    .IFID_PC(ifid_pc), .IFID_INSTR(ifid_instr), .IFID_VALID(valid),
    .HALTED(halted), .FAULT(fault), .FETCH_COUNT(fcount)
  );

  if_stage #(.TAM_POSICIONES(4)) dut4 (
    .CLK(clk), .RESET(rst2), .INS_ADDRESS(addr2), .INSTRUCTION_IN(rom[{8'd0, addr2}]),
    .STALL(1'b0), .REDIRECT(1'b0), .TARGET(32'd0),
    .IFID_PC(ifid_pc2), .IFID_INSTR(ifid_instr2), .IFID_VALID(valid2),
    .HALTED(halted2), .FAULT(fault2), .FETCH_COUNT(fcount2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input logic [31:0] pc, input logic [31:0] cnt);
    sb.push_back('{pc: pc, instr: rom[pc[11:2]], cnt: cnt});
    step();
  endtask

  // monitor: each new latch (count moved to a non-zero value) pops one expectation
  always @(negedge clk) begin
    if (fcount !== prev_cnt && fcount != 0) begin
      if (sb.size() == 0) chk("sb_unexpected_latch", fcount, prev_cnt);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_valid", {31'd0, valid}, 32'd1);
        chk("sb_pc", ifid_pc, e.pc);
        chk("sb_instr", ifid_instr, e.instr);
        chk("sb_count", fcount, e.cnt);
      end
    end
    prev_cnt <= fcount;
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0093 | (i << 20);
    rom[5] = EBR;
    step();
    chk("rst_addr", {22'd0, addr}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_count", fcount, 0);
    chk("rst_flags", {30'd0, halted, fault}, 0);
    rst = 0;
    rst2 = 0;
    step();
    chk("boot_addr", {22'd0, addr}, 0);
    chk("boot_valid", {31'd0, valid}, 0);
    adv(32'h0, 1);
    chk("addr1", {22'd0, addr}, 1);
    adv(32'h4, 2);
    chk("addr2", {22'd0, addr}, 2);
    chk("d4_count2", fcount2, 2);
    stall = 1;
    step();
    step();
    chk("d4_fault", {31'd0, fault2}, 1);
    chk("d4_pc", ifid_pc2, 32'hC);
    chk("d4_instr", ifid_instr2, rom[3]);
    chk("d4_valid", {31'd0, valid2}, 1);
    chk("d4_count4", fcount2, 4);
    chk("d4_addr", {30'd0, addr2}, 3);
    chk("stall_addr", {22'd0, addr}, 2);
    chk("stall_ifid_pc", ifid_pc, 4);
    chk("stall_count", fcount, 2);
    stall = 0;
    adv(32'h8, 3);
    chk("d4_bubble", {31'd0, valid2}, 0);
    chk("d4_fault_held", {fcount2[30:0], fault2}, {31'd4, 1'b1});
    chk("addr3", {22'd0, addr}, 3);
    stall = 1;
    redirect = 1;
    target = 32'h40;
    step();
    chk("redir_addr", {22'd0, addr}, 32'h10);
    chk("redir_valid", {31'd0, valid}, 0);
    chk("redir_instr", ifid_instr, NOP);
    chk("redir_count", fcount, 3);
    stall = 0;
    target = 32'hC;
    step();
    redirect = 0;
    chk("redir2_addr", {22'd0, addr}, 3);
    adv(32'hC, 4);
    adv(32'h10, 5);
    adv(32'h14, 6);
    chk("halt_on", {31'd0, halted}, 1);
    chk("halt_addr", {22'd0, addr}, 5);
    stall = 1;
    step();
    chk("halt_stall_instr", ifid_instr, EBR);
    chk("halt_stall_valid", {31'd0, valid}, 1);
    stall = 0;
    step();
    chk("halt_bubble", {31'd0, valid}, 0);
    chk("halt_addr2", {22'd0, addr}, 5);
    chk("halt_still", {31'd0, halted}, 1);
    redirect = 1;
    target = 32'h10;
    step();
    redirect = 0;
    chk("unhalt", {31'd0, halted}, 0);
    chk("unhalt_addr", {22'd0, addr}, 4);
    adv(32'h10, 7);
    chk("post_addr", {22'd0, addr}, 5);
    redirect = 1;
    target = 32'h42;
    step();
    chk("fault_on", {31'd0, fault}, 1);
    chk("fault_addr", {22'd0, addr}, 5);
    target = 32'h0;
    step();
    redirect = 0;
    step();
    chk("fault_sticky", {31'd0, fault}, 1);
    chk("fault_addr2", {22'd0, addr}, 5);
    chk("fault_count", fcount, 7);
    chk("fault_bubble", {31'd0, valid}, 0);
    rom[5] = 32'h0050_0093;
    rst = 1;
    step();
    rst = 0;
    chk("rst2_fault", {31'd0, fault}, 0);
    chk("rst2_addr", {22'd0, addr}, 0);
    step();
    for (int i = 0; i < 8; i++) adv(32'(i * 4), 32'(i + 1));
    chk("mid_addr", {22'd0, addr}, 8);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_addr", {22'd0, addr}, 0);
    chk("mid_rst_valid", {31'd0, valid}, 0);
    chk("mid_rst_count", fcount, 0);
    step();
    chk("mid_boot_valid", {31'd0, valid}, 0);
    chk("mid_boot_addr", {22'd0, addr}, 0);
    adv(32'h0, 1);
    step();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the asynchronous instruction ROM.
- Owns the PC and drives the ROM word address combinationally.
- Captures the returned instruction, with its PC, into the IF/ID pipeline register consumed by decode.
- Handles stall, branch/jump redirect (flush), EBREAK halt, address faults and a retired-fetch counter.

Parameters:
- TAM_POSICIONES, 1024: ROM depth in words; ADDR_W = $clog2(TAM_POSICIONES).
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013: bubble encoding (ADDI x0,x0,0) placed in IF/ID on flush or idle.
- EBREAK_INSTR, 32'h0010_0073: encoding that halts fetch.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- INS_ADDRESS  out  ADDR_W  ROM word address = PC[ADDR_W+1:2]; combinational from PC.
- INSTRUCTION_IN  in  32  ROM data, valid in the same cycle as INS_ADDRESS.
- STALL  in  1  hazard unit: hold PC and IF/ID.
- REDIRECT  in  1  taken branch/jump from EX: load TARGET and flush IF/ID.
- TARGET  in  32  redirect byte address.
- IFID_PC  out  32  PC of the latched instruction.
- IFID_INSTR  out  32  latched instruction.
- IFID_VALID  out  1  latched instruction is real, not a bubble.
- HALTED  out  1  high while in HALT.
- FAULT  out  1  sticky address fault (misaligned or out-of-ROM PC).
- FETCH_COUNT  out  32  count of valid instructions latched into IF/ID; wraps at 2^32.

Behaviour:
- Reset (synchronous, highest priority): PC=RESET_PC, IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0, HALTED=0, FAULT=0, FETCH_COUNT=0, state=BOOT. Reset mid-operation discards everything in the same edge.
- States: BOOT, RUN, HALT, FAULTED.
- BOOT: one cycle. IF/ID loads a bubble and PC holds. Next state is RUN unless REDIRECT is high, which follows the RUN redirect rules.
- RUN, per-edge priority REDIRECT > STALL > advance:
  - Redirect: if TARGET[1:0]!=0 or TARGET[31:ADDR_W+2]!=0, go to FAULTED; FAULT=1; PC holds; IF/ID gets a bubble. Otherwise PC<=TARGET and IF/ID<=bubble (VALID=0). Redirect overrides STALL.
  - Stall: PC, IF/ID and FETCH_COUNT hold.
  - Advance: IFID_PC<=PC, IFID_INSTR<=INSTRUCTION_IN, IFID_VALID<=1, FETCH_COUNT+=1.
    - If INSTRUCTION_IN==EBREAK_INSTR: PC holds, next state HALT.
    - Else if PC+4 leaves ROM range (PC+4 >> 2 >= TAM_POSICIONES): PC holds, next state FAULTED, FAULT=1. The current instruction is still latched valid.
    - Else PC<=PC+4.
- HALT: HALTED=1.
  - Non-stalled edges: IF/ID loads a bubble, PC holds. Stalled edges hold IF/ID, so the EBREAK is not lost.
  - REDIRECT (EBREAK was wrong-path): apply the RUN redirect rules, HALTED<=0, return to RUN.
- FAULTED: FAULT=1, HALTED=0. IF/ID gets a bubble on non-stalled edges. REDIRECT and STALL are otherwise ignored; exit only via RESET.
- Latency: instruction at PC appears on IFID_* one edge after PC is presented. Redirect penalty: one bubble.
- Arithmetic: PC+4 is 32-bit unsigned; overflow cannot occur because the range check faults first.
- INS_ADDRESS is always driven from PC, including in HALT and FAULTED.

Decomposition:
- Shared package rv_pkg: NOP_INSTR, EBREAK_INSTR, the 32-bit word typedef, and the fetch state enum {BOOT, RUN, HALT, FAULTED}.
- One natural sub-module, ifid_reg: IF/ID pipeline register with load, flush (bubble) and hold controls. The PC/FSM logic lives in if_stage.

Test Plan:
- Reset then run with ROM holding ADDI words at 0..3, no stall → INS_ADDRESS 0,1,2,3 on consecutive cycles; IFID_PC 0,4,8 with VALID=1 starting the cycle after BOOT; FETCH_COUNT=3 after 3 advances.
- STALL high for 2 cycles with PC=8 → INS_ADDRESS stays 2; IFID_PC stays 4; FETCH_COUNT unchanged. STALL and REDIRECT(TARGET=0x40) together → PC=0x40, IFID_VALID=0, IFID_INSTR=0x00000013.
- ROM word 5 = 0x00100073 → IFID_INSTR=0x00100073 valid, then HALTED=1, IFID_VALID=0, INS_ADDRESS stuck at 5. REDIRECT TARGET=0x10 → HALTED=0, next fetch at word 4.
- REDIRECT TARGET=0x42 → FAULT=1; PC unchanged; later REDIRECT TARGET=0x0 ignored; RESET → FAULT=0, PC=0.
- TAM_POSICIONES=4, run from 0 → words 0..3 latched valid, then FAULT=1 with PC=0xC held.
- Assert RESET mid-run at PC=0x20 → next edge PC=0, IFID_VALID=0, FETCH_COUNT=0, state BOOT.
